rf_access_arbiter: RTL and testbench

//  Shares the single Register_File access port (WrEn/RdEn/Address/WrData -> RdData/RdData_valid)

---
 rtl/rf_arb_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/rf_access_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_access_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared state encoding and timeout counter sizing for rf_access_arbiter
package rf_arb_pkg;
  localparam int ST_W     = 2;
  localparam int TO_CNT_W = 8;
  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request after i_last wins
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);
  // scan from farthest to nearest so the nearest request after i_last overwrites
  always_comb begin
    logic [IW:0] j;
    o_idx = '0;
    for (int i = N; i >= 1; i--) begin
      j = {1'b0, i_last} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (i_req[j[IW-1:0]]) o_idx = j[IW-1:0];
    end
  end
  assign o_grant = (|i_req) ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin sharing of the Register_File port (optional macro RF_ARB_TIMEOUT_EN)
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_WR,
  input  logic [NUM_REQ*RF_ADDR-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          RSP_ERR,
  output logic                          WrEn,
  output logic                          RdEn,
  output logic [RF_ADDR-1:0]            Address,
  output logic [DATA_WIDTH-1:0]         WrData,
  input  logic [DATA_WIDTH-1:0]         RdData,
  input  logic                          RdData_valid
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= 2**TO_CNT_W) begin : g_bad_cfg
    $error("rf_access_arbiter: unsupported parameter set");
  end

  state_t                r_state, w_next;
  logic [IW-1:0]         r_last, w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  r_wr;
  logic [RF_ADDR-1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic                  w_timeout;
  logic                  w_accept, w_done;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req   (REQ_VALID),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|REQ_VALID);
  assign w_done   = (r_state == WAIT) && (RdData_valid || w_timeout);
  assign Address  = r_addr;
  assign WrData   = r_wdata;
  assign RSP_DATA = r_rdata;

`ifdef RF_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_err;
  assign w_timeout = (r_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));
  // count WAIT cycles (zero outside WAIT, so it is clear on entry) and record why WAIT ended
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == WAIT) r_err <= ~RdData_valid;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next state and decoded strobes; READY is masked while reset is held
  always_comb begin
    w_next    = r_state;
    REQ_READY = '0;
    RSP_VALID = '0;
    RSP_ERR   = 1'b0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    case (r_state)
      IDLE: begin
        REQ_READY = RST ? w_grant : '0;
        if (|REQ_VALID) w_next = ISSUE;
      end
      ISSUE: begin
        WrEn   = r_wr;
        RdEn   = ~r_wr;
        w_next = r_wr ? IDLE : WAIT;
      end
      WAIT: if (RdData_valid || w_timeout) w_next = RESP;
      default: begin
        RSP_VALID = NUM_REQ'(1) << r_last;
`ifdef RF_ARB_TIMEOUT_EN
        RSP_ERR   = r_err;
`endif
        w_next    = IDLE;
      end
    endcase
  end

  // latch the winner's request and capture the read result (zero on timeout)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_last  <= w_idx;
        r_wr    <= REQ_WR[w_idx];
        r_addr  <= REQ_ADDR[w_idx*RF_ADDR +: RF_ADDR];
        r_wdata <= REQ_WDATA[w_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_done) r_rdata <= RdData_valid ? RdData : '0;
    end
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: directed checks of grant order, latency, routing, timeout and reset abort
module tb_rf_access_arbiter;
  logic        CLK, RST;
  logic [1:0]  REQ_VALID, REQ_WR, REQ_READY, RSP_VALID;
  logic [7:0]  REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic [7:0]  RSP_DATA, WrData, RdData;
  logic        RSP_ERR, WrEn, RdEn, RdData_valid;
  logic [3:0]  Address;
  logic [7:0]  rf [16];
  logic        rf_en;
  int          n_chk, n_err;

  rf_access_arbiter #(.DATA_WIDTH(8), .RF_ADDR(4), .NUM_REQ(2), .TIMEOUT_CYC(15)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_valid(RdData_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // register file model: write on WrEn, read data one cycle after RdEn (suppressible)
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    rf[2] = 8'h81;
    RdData_valid = 1'b0;
    RdData = 8'h00;
  end
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    RdData_valid <= RdEn & rf_en;
    RdData       <= rf[Address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0;
    RST = 1'b0; rf_en = 1'b1;
    REQ_VALID = 2'b11; REQ_WR = 2'b00; REQ_ADDR = 8'h00; REQ_WDATA = 16'h0000;
    repeat (2) @(posedge CLK);
    #3;
    chk("rst_ready", REQ_READY, 2'b00);
    chk("rst_wren", WrEn, 1'b0);
    chk("rst_rden", RdEn, 1'b0);
    chk("rst_rspv", RSP_VALID, 2'b00);
    chk("rst_addr", Address, 4'h0);
    chk("rst_rspd", RSP_DATA, 8'h00);
    chk("rst_err", RSP_ERR, 1'b0);
    REQ_VALID = 2'b00;
    RST = 1'b1;
    step;
    // write from req0
    REQ_VALID = 2'b01; REQ_WR = 2'b01; REQ_ADDR = {4'd0, 4'd4}; REQ_WDATA = {8'h00, 8'h5A};
    #1 chk("t1_ready", REQ_READY, 2'b01);
    step; REQ_VALID = 2'b00;
    #1 chk("t1_wren", WrEn, 1'b1);
    chk("t1_rden", RdEn, 1'b0);
    chk("t1_addr", Address, 4'd4);
    chk("t1_wdata", WrData, 8'h5A);
    chk("t1_ready_issue", REQ_READY, 2'b00);
    step;
    #1 chk("t1_wren_off", WrEn, 1'b0);
    chk("t1_addr_hold", Address, 4'd4);
    // read from req1, granted two cycles after the write accept
    REQ_VALID = 2'b10; REQ_WR = 2'b00; REQ_ADDR = {4'd2, 4'd0};
    #1 chk("t2_ready", REQ_READY, 2'b10);
    step; REQ_VALID = 2'b00;
    #1 chk("t2_rden", RdEn, 1'b1);
    chk("t2_wren", WrEn, 1'b0);
    chk("t2_addr", Address, 4'd2);
    step;
    #1 chk("t2_rspv_wait", RSP_VALID, 2'b00);
    step;
    #1 chk("t2_rspv", RSP_VALID, 2'b10);
    chk("t2_rspd", RSP_DATA, 8'h81);
    chk("t2_err", RSP_ERR, 1'b0);
    step;
    #1 chk("t2_rspv_off", RSP_VALID, 2'b00);
    // both requesters writing continuously after reset: 0,1,0,1
    RST = 1'b0;
    #1 RST = 1'b1;
    REQ_VALID = 2'b11; REQ_WR = 2'b11; REQ_ADDR = {4'd3, 4'd1}; REQ_WDATA = {8'h33, 8'h11};
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_ready", REQ_READY, (k % 2) ? 2'b10 : 2'b01);
      step;
      #1 chk("t3_wren", WrEn, 1'b1);
      chk("t3_addr", Address, (k % 2) ? 4'd3 : 4'd1);
      chk("t3_wdata", WrData, (k % 2) ? 8'h33 : 8'h11);
      step;
    end
    REQ_VALID = 2'b00;
    // req0 read then drops valid; req1 waits until IDLE
    REQ_VALID = 2'b01; REQ_WR = 2'b00; REQ_ADDR = {4'd1, 4'd4};
    #1 chk("t4_ready", REQ_READY, 2'b01);
    step; REQ_VALID = 2'b10;
    #1 chk("t4_ready_issue", REQ_READY, 2'b00);
    chk("t4_rden", RdEn, 1'b1);
    chk("t4_addr", Address, 4'd4);
    step;
    #1 chk("t4_ready_wait", REQ_READY, 2'b00);
    step;
    #1 chk("t4_ready_resp", REQ_READY, 2'b00);
    chk("t4_rspv", RSP_VALID, 2'b01);
    chk("t4_rspd", RSP_DATA, 8'h5A);
    step;
    #1 chk("t4_ready_idle", REQ_READY, 2'b10);
    step; REQ_VALID = 2'b00;
    #1 chk("t4b_rden", RdEn, 1'b1);
    chk("t4b_addr", Address, 4'd1);
    step;
    step;
    #1 chk("t4b_rspv", RSP_VALID, 2'b10);
    chk("t4b_rspd", RSP_DATA, 8'h11);
    step;
    // read with no RdData_valid ever returned
    rf_en = 1'b0;
    REQ_VALID = 2'b01; REQ_WR = 2'b00; REQ_ADDR = {4'd0, 4'd3};
    #1 chk("t5_ready", REQ_READY, 2'b01);
    step; REQ_VALID = 2'b00;
    #1 chk("t5_rden", RdEn, 1'b1);
    for (int c = 0; c < 15; c++) begin
      step;
      #1 chk("t5_wait_rspv", RSP_VALID, 2'b00);
    end
    step;
`ifdef RF_ARB_TIMEOUT_EN
    #1 chk("t5_to_rspv", RSP_VALID, 2'b01);
    chk("t5_to_rspd", RSP_DATA, 8'h00);
    chk("t5_to_err", RSP_ERR, 1'b1);
`else
    #1 chk("t5_stuck_rspv", RSP_VALID, 2'b00);
    chk("t5_stuck_err", RSP_ERR, 1'b0);
    chk("t5_stuck_ready", REQ_READY, 2'b00);
`endif
    RST = 1'b0;
    #1 chk("t5_rst_rspv", RSP_VALID, 2'b00);
    RST = 1'b1;
    // reset while waiting for read data that is about to arrive
    rf_en = 1'b1;
    step;
    REQ_VALID = 2'b10; REQ_WR = 2'b00; REQ_ADDR = {4'd2, 4'd0};
    #1 chk("t6_ready", REQ_READY, 2'b10);
    step; REQ_VALID = 2'b00;
    #1 chk("t6_rden", RdEn, 1'b1);
    step;
    chk("t6_rdvalid_present", RdData_valid, 1'b1);
    RST = 1'b0;
    #1 chk("t6_rden_rst", RdEn, 1'b0);
    chk("t6_rspv_rst", RSP_VALID, 2'b00);
    chk("t6_addr_rst", Address, 4'd0);
    step;
    #1 chk("t6_rspv_after", RSP_VALID, 2'b00);
    RST = 1'b1;
    REQ_VALID = 2'b11;
    #1 chk("t6_first_grant", REQ_READY, 2'b01);
    REQ_VALID = 2'b00;
    step;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
